// File: rtl/vga_pixel_serializer8x16_if.sv
// Pixel-path bundle between the font-ROM/sync front end and the VGA serializer.
interface vga_pixel_serializer8x16_if;
  logic [9:0]  Qh_px;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [7:0]  DATO8x16;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;

  modport master (
    output Qh_px, video_on, hsync_in, vsync_in, DATO8x16,
    input  rgb, hsync, vsync
  );

  modport slave (
    input  Qh_px, video_on, hsync_in, vsync_in, DATO8x16,
    output rgb, hsync, vsync
  );
endinterface

// File: rtl/vga_pixel_serializer8x16.sv
// Serializes 8-bit font rows MSB-first, one pixel per clock, with column/enable/sync
// delayed to meet the ROM data; drives registered RGB and sync to the connector.
module vga_pixel_serializer8x16 #(
  parameter int          ROM_LAT  = 2,
  parameter logic [11:0] FG       = 12'hFFF,
  parameter logic [11:0] BG       = 12'h000,
  parameter logic        SYNC_POL = 1'b0
) (
  input logic                        reloj,
  input logic                        resetM,
  vga_pixel_serializer8x16_if.slave  vif
);

  typedef struct packed {
    logic [2:0] idx;
    logic       von;
    logic       hs;
    logic       vs;
  } tap_t;

  localparam tap_t TAP_RST = '{idx: 3'd0, von: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  tap_t [ROM_LAT-1:0] align;
  logic [ROM_LAT-1:0] vld_pipe;
  tap_t               cur;
  tap_t               tap;
  logic               load;
  logic               pix;
  logic [7:0]         shreg;
  logic [7:0]         shreg_nxt;
  logic               unused_qh;

  assign unused_qh = ^vif.Qh_px[9:3];

  always_comb begin
    cur     = TAP_RST;
    cur.idx = vif.Qh_px[2:0];
    cur.von = vif.video_on;
    cur.hs  = vif.hsync_in;
    cur.vs  = vif.vsync_in;
  end

  // Align pipeline; vld_pipe marks entries that came from real input, so the
  // reset-filled idx=0 slots never load a glyph.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      align    <= {ROM_LAT{TAP_RST}};
      vld_pipe <= '0;
    end else begin
      align[0]    <= cur;
      vld_pipe[0] <= 1'b1;
      for (int i = 1; i < ROM_LAT; i++) begin
        align[i]    <= align[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign tap  = align[ROM_LAT-1];
  assign load = vld_pipe[ROM_LAT-1] && (tap.idx == 3'd0);

  always_comb begin
    pix       = shreg[7];
    shreg_nxt = {shreg[6:0], 1'b0};
    if (load) begin
      pix       = vif.DATO8x16[7];
      shreg_nxt = {vif.DATO8x16[6:0], 1'b0};
    end
  end

  // Shifting runs regardless of video_on so blanking never desynchronizes the glyph.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      shreg     <= 8'h00;
      vif.rgb   <= 12'h000;
      vif.hsync <= ~SYNC_POL;
      vif.vsync <= ~SYNC_POL;
    end else begin
      shreg     <= shreg_nxt;
      vif.rgb   <= tap.von ? (pix ? FG : BG) : 12'h000;
      vif.hsync <= tap.hs;
      vif.vsync <= tap.vs;
    end
  end

endmodule

// File: tb/tb_vga_pixel_serializer8x16.sv
// Directed bench for vga_pixel_serializer8x16 (ROM_LAT=2) with a 2-deep ROM delay model.
module tb_vga_pixel_serializer8x16;
  logic reloj = 1'b0;
  logic resetM;
  always #5 reloj = ~reloj;

  vga_pixel_serializer8x16_if vif();

  vga_pixel_serializer8x16 #(
    .ROM_LAT (2),
    .FG      (12'hFFF),
    .BG      (12'h000),
    .SYNC_POL(1'b0)
  ) dut (
    .reloj (reloj),
    .resetM(resetM),
    .vif   (vif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t       eq[$];
  logic [7:0] gq[$];

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output is expected 3 edges after a slot is driven; ROM byte 2 slots after its address.
  task automatic preseed();
    exp_t e;
    eq.delete();
    gq.delete();
    e.tag = "post_reset"; e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
    repeat (2) begin
      eq.push_back(e);
      gq.push_back(8'hFF);
    end
  endtask

  task automatic slot(input string tag, input logic [9:0] qh, input logic von,
                      input logic hs, input logic vs, input logic [7:0] glyph,
                      input logic [11:0] erg, input logic ehs, input logic evs);
    exp_t e;
    vif.Qh_px    = qh;
    vif.video_on = von;
    vif.hsync_in = hs;
    vif.vsync_in = vs;
    gq.push_back(glyph);
    vif.DATO8x16 = gq.pop_front();
    e.tag = tag; e.rgb = erg; e.hs = ehs; e.vs = evs;
    eq.push_back(e);
    @(posedge reloj);
    #1;
    e = eq.pop_front();
    check({e.tag, "_rgb"}, vif.rgb, e.rgb);
    check({e.tag, "_hs"}, {11'b0, vif.hsync}, {11'b0, e.hs});
    check({e.tag, "_vs"}, {11'b0, vif.vsync}, {11'b0, e.vs});
  endtask

  logic [11:0] exp_row [16] = '{
    12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF,
    12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
  logic [11:0] exp_3c [8] = '{
    12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetM       = 1'b1;
    vif.Qh_px    = 10'd0;
    vif.video_on = 1'b1;
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b0;
    vif.DATO8x16 = 8'hFF;
    #2 resetM = 1'b0;
    #1;
    check("rst_rgb", vif.rgb, 12'h000);
    check("rst_hs", {11'b0, vif.hsync}, 12'h001);
    check("rst_vs", {11'b0, vif.vsync}, 12'h001);
    repeat (3) @(posedge reloj);
    #1;
    check("rst_hold_rgb", vif.rgb, 12'h000);
    check("rst_hold_hs", {11'b0, vif.hsync}, 12'h001);

    @(negedge reloj);
    resetM = 1'b1;
    preseed();

    // Glyph row A5 then 3C
    for (int i = 0; i < 16; i++)
      slot($sformatf("row%0d", i), 10'(i), 1'b1, 1'b1, 1'b1,
           (i < 8) ? 8'hA5 : 8'h3C, exp_row[i], 1'b1, 1'b1);

    // ROM byte drops to 00 after the load: whole character stays lit
    for (int i = 0; i < 8; i++)
      slot($sformatf("midch%0d", i), 10'(i), 1'b1, 1'b1, 1'b1,
           (i < 3) ? 8'hFF : 8'h00, 12'hFFF, 1'b1, 1'b1);
    for (int i = 8; i < 16; i++)
      slot($sformatf("midch%0d", i), 10'(i), 1'b1, 1'b1, 1'b1,
           8'h00, 12'h000, 1'b1, 1'b1);

    // Blanking window idx 4..11
    for (int i = 0; i < 16; i++) begin
      logic von;
      von = !(i >= 4 && i <= 11);
      slot($sformatf("blank%0d", i), 10'(i), von, 1'b1, 1'b1,
           8'hFF, von ? 12'hFFF : 12'h000, 1'b1, 1'b1);
    end

    // Sync pulses at 656 (hsync) and 657 (vsync); lit pixels at 655 and 656
    for (int i = 0; i < 16; i++) begin
      logic hs, vs;
      hs = (i != 8);
      vs = (i != 9);
      slot($sformatf("sync%0d", 648 + i), 10'(648 + i), 1'b1, hs, vs,
           (i < 8) ? 8'h01 : 8'h80, (i == 7 || i == 8) ? 12'hFFF : 12'h000, hs, vs);
    end

    // Async reset mid-line after idx 5
    for (int i = 0; i < 6; i++)
      slot($sformatf("arst%0d", i), 10'(i), 1'b1, (i != 3), 1'b1,
           8'hFF, 12'hFFF, (i != 3), 1'b1);
    resetM = 1'b0;
    #1;
    check("arst_now_rgb", vif.rgb, 12'h000);
    check("arst_now_hs", {11'b0, vif.hsync}, 12'h001);
    eq.delete();
    @(posedge reloj);
    @(negedge reloj);
    resetM = 1'b1;
    preseed();
    for (int i = 8; i < 16; i++)
      slot($sformatf("rel%0d", i), 10'(i), 1'b1, 1'b1, 1'b1,
           8'h3C, exp_3c[i-8], 1'b1, 1'b1);
    for (int i = 0; i < 2; i++)
      slot($sformatf("flush%0d", i), 10'd16, 1'b0, 1'b1, 1'b1,
           8'h00, 12'h000, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pixel_serializer8x16.md
# vga_pixel_serializer8x16

Downstream consumer of the 8x16 font-ROM address stage. It takes the 8-bit font row returned by the character ROM for the address that stage produced and serializes it MSB-first into one pixel per clock. It delays the pixel column index, video-enable and sync signals so they line up with the ROM data, and drives the registered 12-bit RGB and sync outputs to the VGA connector.

## Interface
- ROM_LAT, 2: clock cycles from presenting Qh/Qv to the address stage until the matching DATO8x16 is valid at this block's input (address-stage register + synchronous ROM read); legal 1..7
- FG, 12'hFFF: RGB for a set font bit
- BG, 12'h000: RGB for a clear font bit inside the visible area
- SYNC_POL, 1'b0: active level of hsync/vsync (0 = active-low)

- reloj  in  1  pixel clock; all state updates on rising edge
- resetM  in  1  asynchronous, active-low reset
- Qh_px  in  10  current pixel column (same cycle as Qh/Qv to address stage); only [2:0] used
- video_on  in  1  1 = current pixel in visible area
- hsync_in  in  1  horizontal sync from the sync generator, same cycle as Qh_px
- vsync_in  in  1  vertical sync, same cycle as Qh_px
- DATO8x16  in  8  font row from ROM; bit 7 = leftmost pixel
- rgb  out  12  registered pixel colour {R[3:0],G[3:0],B[3:0]}
- hsync  out  1  registered, delayed hsync_in
- vsync  out  1  registered, delayed vsync_in

## Operation
- Align pipeline: ROM_LAT-deep shift register carrying {Qh_px[2:0], video_on, hsync_in, vsync_in}. Tap outputs are idx_d, von_d, hs_d, vs_d and are cycle-aligned with DATO8x16.
- Serializer: 8-bit shift register shreg. Each cycle:
  - idx_d == 0 (load): pix = DATO8x16[7]; shreg <= {DATO8x16[6:0],1'b0}
  - otherwise: pix = shreg[7]; shreg <= {shreg[6:0],1'b0}
- DATO8x16 is sampled only on load cycles. The ROM byte may change mid-character without effect.
- Output register:
  - rgb <= von_d ? (pix ? FG : BG) : 12'h000
  - hsync <= hs_d; vsync <= vs_d
- Address 0 from the upstream stage means blank. The ROM returns 8'h00 there, so the output is BG with no special case.
- Non-contiguous idx_d, e.g. a column jump at line wrap: the next load happens only at idx_d == 0. Pixels between the jump and that load come from the residual shreg, which empties to zeros (BG) after at most 8 cycles.

## Timing
- Latency Qh_px/video_on/syncs → rgb/hsync/vsync: exactly ROM_LAT+1 cycles. Syncs and pixels stay mutually aligned.
- One pixel per clock. No stall or handshake; throughput is 1/clock continuously.
- Reset (resetM low, asynchronous assert):
  - align pipeline cleared: idx_d = 0, von_d = 0, syncs = ~SYNC_POL
  - shreg = 8'h00
  - rgb = 12'h000
  - hsync = vsync = ~SYNC_POL (inactive)
- Reset deassertion is sampled synchronously. The first ROM_LAT+1 output cycles after release are black with inactive syncs. No partial glyph is emitted until the first real idx_d == 0 load.
- Reset mid-line: outputs go black/inactive immediately, asynchronously. Serialization restarts cleanly at the next character boundary.
- video_on falling mid-character: rgb goes black on the delayed cycle. Shifting continues regardless of video_on.

## Test plan
- Reset: hold resetM=0, drive DATO8x16=8'hFF, video_on=1 → rgb=12'h000 and hsync=vsync=1. After release, the first 3 cycles (ROM_LAT=2) stay black.
- Glyph row: Qh_px counting 0..15 with video_on=1, DATO8x16=8'hA5 aligned to idx 0..7 and 8'h3C for idx 8..15 → from cycle 3, rgb = FFF,000,FFF,000,000,FFF,000,FFF, then 000,000,FFF,FFF,FFF,FFF,000,000.
- Mid-character ROM change: DATO8x16 switches 8'hFF→8'h00 at idx_d=3 → all 8 pixels of that character are FFF.
- Blanking: video_on=0 for idx 4..11 with DATO=8'hFF → rgb 000 exactly on those pixels, delayed 3 cycles; FFF elsewhere.
- Sync alignment: single-cycle hsync_in pulse (low) at Qh_px=656 → hsync low exactly 3 cycles later for 1 cycle, same cycle as the pixel for column 656.
- Async reset mid-line at idx 5: rgb clears within the same cycle with no clock edge. After release, output is black until the first load at idx_d=0, then the correct glyph.
